mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_pkg.sv | 55 +++++
 rtl/instret_counter.sv | 27 ++
 rtl/mc_control.sv | 164 ++++++++++++++++
 tb/tb_mc_control.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle control FSM.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch, StDecode, StExecR, StExecI, StExecU, StMemAddr, StMemRd,
        StMemWr, StWbAlu, StWbMem, StBranch, StJal, StJalr, StTrap
    } state_e;

    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [1:0] PcSelAlu     = 2'd0;
    localparam logic [1:0] PcSelAluOut  = 2'd1;
    localparam logic [1:0] PcSelAluClr0 = 2'd2;

    localparam logic [1:0] AluASelPc    = 2'd0;
    localparam logic [1:0] AluASelOldPc = 2'd1;
    localparam logic [1:0] AluASelRs1   = 2'd2;
    localparam logic [1:0] AluASelZero  = 2'd3;

    localparam logic [1:0] AluBSelRs2   = 2'd0;
    localparam logic [1:0] AluBSelImm   = 2'd1;
    localparam logic [1:0] AluBSelFour  = 2'd2;

    localparam logic [1:0] AluOpAdd     = 2'd0;
    localparam logic [1:0] AluOpCmp     = 2'd1;
    localparam logic [1:0] AluOpFunct   = 2'd2;

    localparam logic [1:0] WbSelAluOut  = 2'd0;
    localparam logic [1:0] WbSelMdr     = 2'd1;
    localparam logic [1:0] WbSelPc      = 2'd2;

    function automatic state_e decode_next(input logic [6:0] op);
        state_e st;
        unique case (op)
            OpRType:          st = StExecR;
            OpIType:          st = StExecI;
            OpLoad, OpStore:  st = StMemAddr;
            OpBranch:         st = StBranch;
            OpJal:            st = StJal;
            OpJalr:           st = StJalr;
            OpLui, OpAuipc:   st = StExecU;
            default:          st = StTrap;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/instret_counter.sv
// Retired-instruction counter; wraps naturally at 32 bits.
module instret_counter
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q + {31'd0, inc};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mc_control.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, execute, memory and writeback
// strobes/selects for a shared-ALU datapath.
module mc_control
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        old_pc_we,
    output logic        ir_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [1:0]  alu_op,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [31:0] instret
);

    state_e state_q, state_d;
    logic   retire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_we     = 1'b0;
        pc_sel    = PcSelAlu;
        old_pc_we = 1'b0;
        ir_we     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        alu_a_sel = AluASelPc;
        alu_b_sel = AluBSelRs2;
        alu_op    = AluOpAdd;
        rf_we     = 1'b0;
        wb_sel    = WbSelAluOut;
        illegal   = 1'b0;

        unique case (state_q)
            StFetch: begin
                mem_req   = 1'b1;
                alu_b_sel = AluBSelFour;
                if (mem_ready) begin
                    ir_we     = 1'b1;
                    old_pc_we = 1'b1;
                    pc_we     = 1'b1;
                    state_d   = StDecode;
                end
            end
            StDecode: begin
                // Branch/JAL target is precomputed here into ALUOut.
                alu_a_sel = AluASelOldPc;
                alu_b_sel = AluBSelImm;
                state_d   = decode_next(opcode);
            end
            StExecR: begin
                alu_a_sel = AluASelRs1;
                alu_op    = AluOpFunct;
                state_d   = StWbAlu;
            end
            StExecI: begin
                alu_a_sel = AluASelRs1;
                alu_b_sel = AluBSelImm;
                alu_op    = AluOpFunct;
                state_d   = StWbAlu;
            end
            StExecU: begin
                alu_a_sel = (opcode == OpLui) ? AluASelZero : AluASelOldPc;
                alu_b_sel = AluBSelImm;
                state_d   = StWbAlu;
            end
            StMemAddr: begin
                alu_a_sel = AluASelRs1;
                alu_b_sel = AluBSelImm;
                state_d   = (opcode == OpLoad) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                if (mem_ready) state_d = StWbMem;
            end
            StMemWr: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
                if (mem_ready) state_d = StFetch;
            end
            StWbAlu: begin
                rf_we   = 1'b1;
                state_d = StFetch;
            end
            StWbMem: begin
                rf_we   = 1'b1;
                wb_sel  = WbSelMdr;
                state_d = StFetch;
            end
            StBranch: begin
                alu_a_sel = AluASelRs1;
                alu_op    = AluOpCmp;
                pc_sel    = PcSelAluOut;
                pc_we     = branch_taken;
                state_d   = StFetch;
            end
            StJal: begin
                rf_we   = 1'b1;
                wb_sel  = WbSelPc;
                pc_we   = 1'b1;
                pc_sel  = PcSelAluOut;
                state_d = StFetch;
            end
            StJalr: begin
                rf_we     = 1'b1;
                wb_sel    = WbSelPc;
                pc_we     = 1'b1;
                pc_sel    = PcSelAluClr0;
                alu_a_sel = AluASelRs1;
                alu_b_sel = AluBSelImm;
                state_d   = StFetch;
            end
            StTrap: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // Reset must silence strobes immediately, even though state already reads FETCH.
        if (rst) begin
            pc_we     = 1'b0;
            old_pc_we = 1'b0;
            ir_we     = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            rf_we     = 1'b0;
        end
    end

    // Every path back into FETCH from a non-FETCH state completes an instruction.
    assign retire = (state_q != StFetch) && (state_d == StFetch);

    instret_counter u_instret (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire),
        .count (instret)
    );

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed table, corner sequences and random programs.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = '0;
    logic        branch_taken = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_we, old_pc_we, ir_we, mem_req, mem_we, addr_sel, rf_we, illegal;
    logic [1:0]  pc_sel, alu_a_sel, alu_b_sel, alu_op, wb_sel;
    logic [31:0] instret;

    mc_control dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .old_pc_we    (old_pc_we),
        .ir_we        (ir_we),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .addr_sel     (addr_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .alu_op       (alu_op),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .illegal      (illegal),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       old_pc_we;
        logic       ir_we;
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic [1:0] a_sel;
        logic [1:0] b_sel;
        logic [1:0] op;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        logic       rdy;
        logic       tk;
        logic [6:0] opc;
        ctl_t       exp;
        logic [3:0] tag;
    } vec_t;

    ctl_t act;
    assign act = {pc_we, pc_sel, old_pc_we, ir_we, mem_req, mem_we, addr_sel,
                  alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel, illegal};

    int          checks = 0;
    int          errors = 0;
    int          rf_seen = 0;
    logic [31:0] exp_instret = '0;
    vec_t        q[$];
    vec_t        add_tbl[4];
    logic [6:0]  legal_ops[9];

    function automatic string tag_name(input logic [3:0] t);
        case (t)
            4'd0:    return "fetch_wait";
            4'd1:    return "fetch";
            4'd2:    return "decode";
            4'd3:    return "exec";
            4'd4:    return "mem_addr";
            4'd5:    return "mem_access";
            4'd7:    return "writeback";
            4'd8:    return "branch";
            4'd9:    return "jump";
            4'd10:   return "trap";
            default: return "other";
        endcase
    endfunction

    function automatic ctl_t mk(input int pw, input int ps, input int ow, input int iw,
                                input int mr, input int mw, input int as, input int a,
                                input int b, input int op, input int rw, input int ws,
                                input int il);
        ctl_t c;
        c.pc_we = 1'(pw);  c.pc_sel = 2'(ps);  c.old_pc_we = 1'(ow); c.ir_we = 1'(iw);
        c.mem_req = 1'(mr); c.mem_we = 1'(mw); c.addr_sel = 1'(as);
        c.a_sel = 2'(a);   c.b_sel = 2'(b);    c.op = 2'(op);
        c.rf_we = 1'(rw);  c.wb_sel = 2'(ws);  c.illegal = 1'(il);
        return c;
    endfunction

    function automatic ctl_t c_fetch(input int rdy);
        return mk(rdy, 0, rdy, rdy, 1, 0, 0, 0, 2, 0, 0, 0, 0);
    endfunction

    task automatic check_ctl(input string name, input ctl_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: controls got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, got, want);
        end
    endtask

    task automatic check_quiet(input string name);
        check32(name, {25'd0, pc_we, old_pc_we, ir_we, mem_req, mem_we, rf_we, illegal}, 32'd0);
    endtask

    task automatic push(input logic r, input logic t, input logic [6:0] o, input ctl_t e,
                        input int tg);
        vec_t v;
        v.rdy = r; v.tk = t; v.opc = o; v.exp = e; v.tag = 4'(tg);
        q.push_back(v);
    endtask

    // Expected per-cycle behaviour of one instruction, from the architectural rules.
    task automatic build(input logic [6:0] opc, input int fw, input int mw, input logic tk);
        for (int i = 0; i < fw; i++) push(1'b0, 1'($urandom), 7'($urandom), c_fetch(0), 0);
        push(1'b1, 1'($urandom), 7'($urandom), c_fetch(1), 1);
        push(1'($urandom), 1'($urandom), opc, mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), 2);
        case (opc)
            7'h33, 7'h13, 7'h37, 7'h17: begin
                if (opc == 7'h33)
                    push(1'($urandom), 1'($urandom), opc, mk(0,0,0,0,0,0,0, 2,0,2, 0,0,0), 3);
                else if (opc == 7'h13)
                    push(1'($urandom), 1'($urandom), opc, mk(0,0,0,0,0,0,0, 2,1,2, 0,0,0), 3);
                else
                    push(1'($urandom), 1'($urandom), opc,
                         mk(0,0,0,0,0,0,0, (opc == 7'h37) ? 3 : 1, 1, 0, 0,0,0), 3);
                push(1'($urandom), 1'($urandom), opc, mk(0,0,0,0,0,0,0, 0,0,0, 1,0,0), 7);
            end
            7'h03, 7'h23: begin
                int st;
                st = (opc == 7'h23) ? 1 : 0;
                push(1'($urandom), 1'($urandom), opc, mk(0,0,0,0,0,0,0, 2,1,0, 0,0,0), 4);
                for (int i = 0; i < mw; i++)
                    push(1'b0, 1'($urandom), opc, mk(0,0,0,0,1,st,1, 0,0,0, 0,0,0), 5);
                push(1'b1, 1'($urandom), opc, mk(0,0,0,0,1,st,1, 0,0,0, 0,0,0), 5);
                if (st == 0)
                    push(1'($urandom), 1'($urandom), opc, mk(0,0,0,0,0,0,0, 0,0,0, 1,1,0), 7);
            end
            7'h63: push(1'($urandom), tk, opc,
                        mk(int'(tk), 1, 0,0,0,0,0, 2,0,1, 0,0,0), 8);
            7'h6F: push(1'($urandom), 1'($urandom), opc, mk(1,1,0,0,0,0,0, 0,0,0, 1,2,0), 9);
            7'h67: push(1'($urandom), 1'($urandom), opc, mk(1,2,0,0,0,0,0, 2,1,0, 1,2,0), 9);
            default: ;
        endcase
    endtask

    task automatic apply_one(input vec_t v);
        @(negedge clk);
        mem_ready    = v.rdy;
        branch_taken = v.tk;
        opcode       = v.opc;
        #1;
        if (rf_we) rf_seen++;
        check_ctl(tag_name(v.tag), v.exp);
        check32("instret", instret, exp_instret);
    endtask

    task automatic apply(input int n);
        for (int i = 0; i < n; i++) apply_one(q[i]);
    endtask

    task automatic run(input logic [6:0] opc, input int fw, input int mw, input logic tk);
        q.delete();
        build(opc, fw, mw, tk);
        apply(q.size());
        q.delete();
        exp_instret = exp_instret + 32'd1;
    endtask

    task automatic reset_pulse(input string name);
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        exp_instret = '0;
        check_quiet({name, "_in_reset"});
        check32({name, "_instret"}, instret, 32'd0);
        @(negedge clk);
        #1;
        check_quiet({name, "_held"});
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        check_ctl({name, "_fresh_fetch"}, c_fetch(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        legal_ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        add_tbl[0] = '{1'b1, 1'b0, 7'h33, mk(1,0,1,1,1,0,0, 0,2,0, 0,0,0), 4'd1};
        add_tbl[1] = '{1'b0, 1'b0, 7'h33, mk(0,0,0,0,0,0,0, 1,1,0, 0,0,0), 4'd2};
        add_tbl[2] = '{1'b1, 1'b1, 7'h33, mk(0,0,0,0,0,0,0, 2,0,2, 0,0,0), 4'd3};
        add_tbl[3] = '{1'b0, 1'b0, 7'h33, mk(0,0,0,0,0,0,0, 0,0,0, 1,0,0), 4'd7};

        // Power-on reset.
        repeat (2) @(negedge clk);
        #1;
        check_quiet("por");
        check32("por_instret", instret, 32'd0);
        rst = 1'b0;
        #1;
        check_ctl("por_fresh_fetch", c_fetch(0));

        // ADD x3,x1,x2 with zero-wait memory.
        for (int i = 0; i < 4; i++) apply_one(add_tbl[i]);
        exp_instret = 32'd1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check32("add_instret", instret, 32'd1);

        // LW with three MEM_RD wait cycles: rf_we exactly once.
        rf_seen = 0;
        run(7'h03, 0, 3, 1'b0);
        check32("lw_rf_we_once", 32'(rf_seen), 32'd1);

        run(7'h63, 0, 0, 1'b0);
        run(7'h63, 0, 0, 1'b1);
        run(7'h67, 0, 0, 1'b0);
        run(7'h6F, 1, 0, 1'b0);
        run(7'h23, 2, 2, 1'b0);
        run(7'h37, 0, 0, 1'b0);
        run(7'h17, 0, 0, 1'b0);

        // Illegal opcode: trapped and silent until reset.
        q.delete();
        push(1'b1, 1'b0, 7'h00, c_fetch(1), 1);
        push(1'b1, 1'b0, 7'h7F, mk(0,0,0,0,0,0,0, 1,1,0, 0,0,0), 2);
        for (int i = 0; i < 100; i++)
            push(1'($urandom), 1'($urandom), 7'($urandom), mk(0,0,0,0,0,0,0, 0,0,0, 0,0,1), 10);
        apply(q.size());
        q.delete();
        reset_pulse("trap_rst");

        // Random program with random fetch and data wait states.
        for (int n = 0; n < 150; n++)
            run(legal_ops[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom));

        // Reset while a store is waiting in MEM_WR.
        q.delete();
        build(7'h23, 0, 3, 1'b0);
        apply(4);
        q.delete();
        reset_pulse("store_rst");

        // Counter wrap from all-ones.
        force dut.u_instret.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_instret.count_q;
        exp_instret = 32'hFFFF_FFFF;
        run(7'h33, 0, 0, 1'b0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check32("instret_wrap", instret, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
